// File: rtl/psg_volume_ramp_pkg.sv
// rtl/psg_volume_ramp_pkg.sv - gain table, gain width and sequencer states for the PSG volume ramp
package psg_pkg;

    localparam int PSG_GW = 8;

    // Roughly 3 dB per volume code; entry 15 is full scale.
    localparam logic [15:0][PSG_GW-1:0] GAIN_TBL = {
        8'd255, 8'd189, 8'd129, 8'd88, 8'd60, 8'd41, 8'd28, 8'd19,
        8'd13,  8'd9,   8'd6,   8'd4,  8'd3,  8'd2,  8'd1,  8'd0
    };

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [PSG_GW-1:0] target_gain(input logic [3:0] vol, input logic mute);
        return mute ? '0 : GAIN_TBL[vol];
    endfunction

endpackage

// File: rtl/psg_volume_ramp_if.sv
// rtl/psg_volume_ramp_if.sv - sample/volume bus between the voice mixers and the volume ramp
interface psg_volume_ramp_if #(
    parameter int NCH = 4,
    parameter int IW  = 22,
    parameter int OW  = 30
);
    logic                sample_valid_i;
    logic [NCH*IW-1:0]   sample_i;
    logic [NCH*4-1:0]    volume_i;
    logic [NCH-1:0]      mute_i;
    logic                ramp_en_i;
    logic [NCH*OW-1:0]   o;
    logic                valid_o;
    logic                busy_o;
    logic                overrun_o;

    modport master (
        output sample_valid_i, sample_i, volume_i, mute_i, ramp_en_i,
        input  o, valid_o, busy_o, overrun_o
    );

    modport slave (
        input  sample_valid_i, sample_i, volume_i, mute_i, ramp_en_i,
        output o, valid_o, busy_o, overrun_o
    );
endinterface

// File: rtl/psg_volume_ramp_gain_ramp.sv
// rtl/psg_volume_ramp_gain_ramp.sv - per-channel current gain, jumping or slewing toward its target
module psg_gain_ramp
    import psg_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              ramp_en,
    input  logic              step,
    input  logic [PSG_GW-1:0] target,
    output logic [PSG_GW-1:0] gain
);

    localparam logic [PSG_GW-1:0] STEP_G = PSG_GW'(STEP);

    logic [PSG_GW-1:0] gain_q;
    logic [PSG_GW-1:0] gain_nxt;
    logic [PSG_GW-1:0] diff_up;
    logic [PSG_GW-1:0] diff_dn;

    assign diff_up = target - gain_q;
    assign diff_dn = gain_q - target;

    // Snap to the target once within one step so the ramp never overshoots.
    always_comb begin
        gain_nxt = gain_q;
        if (!ramp_en) begin
            gain_nxt = target;
        end else if (step) begin
            if (target > gain_q) begin
                gain_nxt = (diff_up <= STEP_G) ? target : gain_q + STEP_G;
            end else if (target < gain_q) begin
                gain_nxt = (diff_dn <= STEP_G) ? target : gain_q - STEP_G;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            gain_q <= '0;
        end else if (load) begin
            gain_q <= gain_nxt;
        end
    end

    assign gain = gain_q;

endmodule

// File: rtl/psg_volume_ramp.sv
// rtl/psg_volume_ramp.sv - multi-channel PSG volume with mute and gain ramping on one shared multiplier
module psg_volume_ramp
    import psg_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int IW       = 22,
    parameter int GW       = PSG_GW,
    parameter int OW       = IW + GW,
    parameter int RAMP_DIV = 16,
    parameter int STEP     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    psg_volume_ramp_if.slave  bus
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

    logic [1:0]          state;
    logic [CW-1:0]       chan;
    logic [CW-1:0]       prod_chan;
    logic                prod_vld;
    logic [OW-1:0]       prod;
    logic [NCH*IW-1:0]   sample_q;
    logic [NCH*OW-1:0]   o_q;
    logic [RW-1:0]       ramp_cnt;
    logic                valid_q;
    logic                busy_q;
    logic                overrun_q;
    logic                accept;
    logic                ramp_step;
    logic [IW-1:0]       samp [NCH];
    logic [GW-1:0]       gain [NCH];

    assign accept    = bus.sample_valid_i && (state == ST_IDLE);
    assign ramp_step = bus.ramp_en_i && (ramp_cnt == RAMP_LAST);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign samp[c] = sample_q[c*IW +: IW];

        psg_gain_ramp #(.STEP(STEP)) u_ramp (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load    (accept),
            .ramp_en (bus.ramp_en_i),
            .step    (ramp_step),
            .target  (target_gain(bus.volume_i[c*4 +: 4], bus.mute_i[c])),
            .gain    (gain[c])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            chan      <= '0;
            prod_chan <= '0;
            prod_vld  <= 1'b0;
            prod      <= '0;
            sample_q  <= '0;
            o_q       <= '0;
            ramp_cnt  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            // Products land one cycle after their multiply slot.
            for (int c = 0; c < NCH; c++) begin
                if (prod_vld && prod_chan == CW'(c)) begin
                    o_q[c*OW +: OW] <= prod;
                end
            end

            if (bus.sample_valid_i && busy_q) begin
                overrun_q <= 1'b1;
            end

            if (accept && bus.ramp_en_i) begin
                ramp_cnt <= ramp_step ? '0 : ramp_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.sample_valid_i) begin
                        sample_q <= bus.sample_i;
                        chan     <= '0;
                        busy_q   <= 1'b1;
                        state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    prod      <= OW'(samp[chan]) * OW'(gain[chan]);
                    prod_chan <= chan;
                    prod_vld  <= 1'b1;
                    chan      <= chan + 1'b1;
                    if (chan == LAST_CH) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    prod_vld <= 1'b0;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o         = o_q;
    assign bus.valid_o   = valid_q;
    assign bus.busy_o    = busy_q;
    assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_psg_volume_ramp.sv
// tb/tb_psg_volume_ramp.sv - self-checking bench for psg_volume_ramp
module tb_psg_volume_ramp;

    localparam int NCH      = 4;
    localparam int IW       = 22;
    localparam int OW       = 30;
    localparam int RAMP_DIV = 2;
    localparam int STEP     = 4;

    logic clk;
    logic rst_n;

    psg_volume_ramp_if #(.NCH(NCH), .IW(IW), .OW(OW)) bus ();

    psg_volume_ramp #(
        .NCH(NCH), .IW(IW), .RAMP_DIV(RAMP_DIV), .STEP(STEP)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int tbl [16] = '{0, 1, 2, 3, 4, 6, 9, 13, 19, 28, 41, 60, 88, 129, 189, 255};
    int m_gain [NCH];
    int m_cnt;

    typedef struct {
        logic [NCH*IW-1:0] smp;
        logic [NCH*4-1:0]  vol;
        logic [NCH-1:0]    mute;
        logic [NCH*OW-1:0] exp_o;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint och(input int c);
        return longint'(bus.o[c*OW +: OW]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) m_gain[c] = 0;
        m_cnt = 0;
    endtask

    task automatic model_accept(input logic [NCH*4-1:0] vol, input logic [NCH-1:0] mute, input logic ren);
        int  tgt;
        int  d;
        bit  stepnow;
        stepnow = 1'b0;
        if (ren) begin
            m_cnt++;
            if (m_cnt == RAMP_DIV) begin
                m_cnt   = 0;
                stepnow = 1'b1;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            tgt = mute[c] ? 0 : tbl[vol[c*4 +: 4]];
            if (!ren) begin
                m_gain[c] = tgt;
            end else if (stepnow) begin
                d = tgt - m_gain[c];
                if (d > STEP)       m_gain[c] += STEP;
                else if (d < -STEP) m_gain[c] -= STEP;
                else                m_gain[c] = tgt;
            end
        end
    endtask

    // Called at the negedge after the accept edge, with lat0 cycles already elapsed.
    task automatic wait_check(input logic [NCH*IW-1:0] smp, input int lat0, input string tag);
        int lat;
        lat = lat0;
        while (!bus.valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, NCH + 1);
        check({tag, "_busy_clear"}, bus.busy_o, 0);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("%s_ch%0d", tag, c), och(c),
                  longint'(smp[c*IW +: IW]) * longint'(m_gain[c]));
        end
    endtask

    task automatic run_frame(input logic [NCH*IW-1:0] smp, input logic [NCH*4-1:0] vol,
                             input logic [NCH-1:0] mute, input logic ren, input string tag);
        bus.sample_i       = smp;
        bus.volume_i       = vol;
        bus.mute_i         = mute;
        bus.ramp_en_i      = ren;
        bus.sample_valid_i = 1'b1;
        model_accept(vol, mute, ren);
        @(negedge clk);
        bus.sample_valid_i = 1'b0;
        bus.volume_i       = NCH*4'($urandom);
        bus.mute_i         = NCH'($urandom);
        bus.sample_i       = {$urandom, $urandom, $urandom};
        wait_check(smp, 0, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*IW-1:0] s1;
        logic [NCH*IW-1:0] rs;
        int  pulses;
        longint e;

        vecs[0] = '{smp: {4{22'd1000}}, vol: {4'd0, 4'd1, 4'd8, 4'd15}, mute: 4'b0000,
                    exp_o: {30'd0, 30'd1000, 30'd19000, 30'd255000}};
        vecs[1] = '{smp: {4{22'd1000}}, vol: 16'hFFFF, mute: 4'b0100,
                    exp_o: {30'd255000, 30'd0, 30'd255000, 30'd255000}};
        vecs[2] = '{smp: {4{22'd1000}}, vol: 16'hFFFF, mute: 4'b0000,
                    exp_o: {4{30'd255000}}};
        vecs[3] = '{smp: {4{22'h3FFFFF}}, vol: 16'hFFFF, mute: 4'b0000,
                    exp_o: {4{30'd1069547265}}};
        vecs[4] = '{smp: {22'd2, 22'd3, 22'd100, 22'd7}, vol: {4'd12, 4'd11, 4'd10, 4'd9}, mute: 4'b0000,
                    exp_o: {30'd176, 30'd180, 30'd4100, 30'd196}};
        vecs[5] = '{smp: {4{22'd10}}, vol: {4'd4, 4'd5, 4'd6, 4'd7}, mute: 4'b0000,
                    exp_o: {30'd40, 30'd60, 30'd90, 30'd130}};

        rst_n              = 1'b0;
        bus.sample_valid_i = 1'b0;
        bus.sample_i       = '0;
        bus.volume_i       = '0;
        bus.mute_i         = '0;
        bus.ramp_en_i      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_o_zero", (bus.o == '0), 1);
        check("reset_valid", bus.valid_o, 0);
        check("reset_busy", bus.busy_o, 0);
        check("reset_overrun", bus.overrun_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Immediate-mode table, issued back to back one cycle after each DONE.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].smp, vecs[i].vol, vecs[i].mute, 1'b0, $sformatf("vec%0d", i));
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("vec%0d_tbl_ch%0d", i, c), och(c),
                      longint'(vecs[i].exp_o[c*OW +: OW]));
            end
        end
        check("b2b_no_overrun", bus.overrun_o, 0);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rs = {$urandom, $urandom, $urandom};
            run_frame(rs, NCH*4'($urandom), NCH'($urandom & $urandom), 1'($urandom),
                      $sformatf("rnd%0d", i));
        end
        check("rnd_no_overrun", bus.overrun_o, 0);

        // Second strobe two cycles after accept must be dropped.
        s1 = {22'd11, 22'd22, 22'd33, 22'd44};
        @(negedge clk);
        bus.sample_i       = s1;
        bus.volume_i       = 16'hFFFF;
        bus.mute_i         = '0;
        bus.ramp_en_i      = 1'b1;
        bus.sample_valid_i = 1'b1;
        model_accept(16'hFFFF, '0, 1'b1);
        @(negedge clk);
        bus.sample_valid_i = 1'b0;
        @(negedge clk);
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = {4{22'd999}};
        bus.volume_i       = 16'h0000;
        @(negedge clk);
        bus.sample_valid_i = 1'b0;
        wait_check(s1, 2, "ovr");
        check("ovr_flag", bus.overrun_o, 1);
        for (int i = 0; i < 4; i++) begin
            run_frame(s1, 16'hFFFF, '0, 1'b1, $sformatf("ovr_post%0d", i));
        end
        check("ovr_sticky", bus.overrun_o, 1);

        // Reset held mid-frame aborts the frame.
        @(negedge clk);
        bus.sample_i       = {4{22'd500}};
        bus.sample_valid_i = 1'b1;
        @(negedge clk);
        bus.sample_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_o_zero", (bus.o == '0), 1);
        check("midrst_valid", bus.valid_o, 0);
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_overrun", bus.overrun_o, 0);
        rst_n = 1'b1;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.valid_o) pulses++;
        end
        check("midrst_no_valid", pulses, 0);

        // Ramp up from 0 to full scale, then back down to exactly 0.
        for (int f = 1; f <= 136; f++) begin
            run_frame({4{22'd1}}, 16'hFFFF, '0, 1'b1, $sformatf("up%0d", f));
            e = (4 * (f / 2) > 255) ? 255 : 4 * (f / 2);
            check($sformatf("up%0d_rule", f), och(0), e);
        end
        check("up_final", och(3), 255);
        for (int f = 1; f <= 136; f++) begin
            run_frame({4{22'd1}}, 16'h0000, '0, 1'b1, $sformatf("dn%0d", f));
            e = (255 - 4 * (f / 2) < 0) ? 0 : 255 - 4 * (f / 2);
            check($sformatf("dn%0d_rule", f), och(0), e);
        end
        check("dn_final", och(3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
